bist_checker: RTL and testbench
===============================

Name: bist_checker

Overview:
- Response-side counterpart of the BIST pattern generators.
- Consumes the patgen stream (addr, re, expected, done) and the SRAM read data.
- Aligns each expected word with the SRAM's fixed read latency, compares the two, and reports pass/fail.
- On failure it also captures the first failing address, the expected word and the actual word.
- Sits between the patgen, the SRAM macro's dout and the BIST status registers.

Parameters:
- ADDR_WIDTH, 5: address width; must match the patgen.
- DATA_WIDTH, 32: data word width.
- READ_LATENCY, 1: cycles from the SRAM read-enable sample to valid dout; legal range 1..4.
- ERR_COUNT_WIDTH, 16: width of the error counter. Used only when the optional feature is enabled.

Ports:
- clk  input  1  single clock, same as the patgen and the SRAM.
- rst  input  1  synchronous, active-high reset.
- en  input  1  BIST step enable, shared with the patgen.
- pg_addr  input  ADDR_WIDTH  patgen address.
- pg_re  input  1  patgen read enable.
- pg_expected  input  DATA_WIDTH  patgen expected data.
- pg_done  input  1  patgen finished.
- dout  input  DATA_WIDTH  SRAM read data.
- done  output  1  checking complete; pipeline drained.
- fail  output  1  sticky mismatch flag.
- fail_addr  output  ADDR_WIDTH  address of the first mismatch.
- fail_expected  output  DATA_WIDTH  expected word of the first mismatch.
- fail_actual  output  DATA_WIDTH  actual dout of the first mismatch.
- err_count  output  ERR_COUNT_WIDTH  saturating mismatch count (optional feature only).

Behaviour:
- Reset values: done, fail and err_count are 0; fail_addr, fail_expected and fail_actual are all-zero; all pipeline valid bits are 0; state is IDLE. Reset asserted mid-test clears everything within one cycle.
- Read pipeline:
  - READ_LATENCY stages, each holding {valid, addr, expected}.
  - Stage 0 loads valid = en & pg_re plus pg_addr and pg_expected.
  - The pipeline shifts every cycle regardless of en, because the SRAM latency is fixed.
  - The last stage aligns with dout.
- Compare:
  - Occurs when the last stage is valid, in the same cycle, combinationally against dout.
  - A mismatch is any bit difference.
- First-fail capture:
  - On a mismatch while fail = 0: the next edge sets fail = 1 and registers fail_addr, fail_expected and fail_actual.
  - Later mismatches never overwrite the capture. fail stays set until rst.
- FSM (states enumerated in the package):
  - IDLE -> RUN when en = 1.
  - RUN -> DRAIN when en & pg_done.
  - DRAIN -> PASS or FAIL once no pipeline stage is valid and the final compare has been applied. FAIL is chosen if fail, or a mismatch in that same cycle, is set.
  - PASS and FAIL are terminal until rst.
- done = 1 only in PASS or FAIL.
- Latency: done rises no earlier than READ_LATENCY+1 cycles after the en & pg_done edge.
- Reads with en = 0 are ignored. pg_re arriving while in DRAIN/PASS/FAIL is ignored (valid forced to 0).
- A simultaneous compare and DRAIN exit is folded into the FAIL decision.

Optional Feature:
- Macro: BIST_CHECKER_ERR_COUNT_EN.
- Defined:
  - err_count port present.
  - Increments by 1 on every mismatch.
  - Saturates at all-ones and never wraps.
  - Cleared by rst.
- Undefined: the port and counter logic are absent; all other behaviour is identical.

Decomposition:
- Package bist_checker_pkg:
  - checker_state_t enum {IDLE, RUN, DRAIN, PASS, FAIL}.
  - Constant MAX_READ_LATENCY = 4.
- Sub-module bist_read_pipe:
  - Parameterised shift pipeline of {valid, addr, expected}, depth READ_LATENCY.
  - Outputs the last stage plus an any_valid flag used for the drain check.

Test Plan:
- Clean run: ADDR_WIDTH=5, READ_LATENCY=1, zero-one pattern, SRAM model correct -> done=1, fail=0, err_count=0; done asserts exactly 2 cycles after en & pg_done.
- Single stuck bit: READ1 at addr 0x0A returns 0xFFFFFFFE -> fail=1, fail_addr=0x0A, fail_expected=0xFFFFFFFF, fail_actual=0xFFFFFFFE, err_count=1, done=1 in state FAIL.
- Multiple faults: mismatches at addr 0x03 then 0x11 -> capture registers hold 0x03's data, err_count=2.
- Latency alignment: READ_LATENCY=3, en toggled 0/1 every other cycle mid-READ0 -> no false mismatches, done only after 3 drain cycles.
- Saturation: ERR_COUNT_WIDTH=2, 5 mismatching reads -> err_count=3, stays 3.
- Reset mid-run: rst pulsed during DRAIN with fail=1 -> next cycle fail=0, done=0, capture regs 0, state IDLE; a rerun passes cleanly.

Source files
------------

// File: rtl/bist_checker_pkg.sv
// Shared types and constants for the BIST response checker.
// The optional error counter is enabled with BIST_CHECKER_ERR_COUNT_EN.
package bist_checker_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    PASS  = 3'd3,
    FAIL  = 3'd4
  } checker_state_t;

  localparam int MAX_READ_LATENCY = 4;

  // Only IDLE and RUN may launch new reads into the compare pipeline.
  function automatic logic accepts_reads(input checker_state_t s);
    return (s == IDLE) || (s == RUN);
  endfunction

  function automatic logic is_terminal(input checker_state_t s);
    return (s == PASS) || (s == FAIL);
  endfunction

endpackage

// File: rtl/bist_read_pipe.sv
// Fixed-depth shift pipeline carrying {valid, addr, expected} so each expected
// word lines up with the SRAM dout of the same read.
module bist_read_pipe
  import bist_checker_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] expected_i,
  output logic                  valid_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] expected_o,
  output logic                  any_valid_o
);

  logic [DEPTH-1:0]      valid_q;
  logic [ADDR_WIDTH-1:0] addr_q     [DEPTH];
  logic [DATA_WIDTH-1:0] expected_q [DEPTH];

  // Shifts every cycle: the SRAM latency does not stall with the BIST enable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i]     <= '0;
        expected_q[i] <= '0;
      end
    end else begin
      valid_q[0]    <= valid_i;
      addr_q[0]     <= addr_i;
      expected_q[0] <= expected_i;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i]    <= valid_q[i-1];
        addr_q[i]     <= addr_q[i-1];
        expected_q[i] <= expected_q[i-1];
      end
    end
  end

  assign valid_o     = valid_q[DEPTH-1];
  assign addr_o      = addr_q[DEPTH-1];
  assign expected_o  = expected_q[DEPTH-1];
  assign any_valid_o = |valid_q;

endmodule

// File: rtl/bist_checker.sv
// BIST response checker: aligns patgen expected data with SRAM dout, captures
// the first mismatch and reports pass/fail. Optional BIST_CHECKER_ERR_COUNT_EN.
module bist_checker
  import bist_checker_pkg::*;
#(
  parameter int ADDR_WIDTH      = 5,
  parameter int DATA_WIDTH      = 32,
  parameter int READ_LATENCY    = 1,
  parameter int ERR_COUNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [ADDR_WIDTH-1:0]      pg_addr,
  input  logic                       pg_re,
  input  logic [DATA_WIDTH-1:0]      pg_expected,
  input  logic                       pg_done,
  input  logic [DATA_WIDTH-1:0]      dout,
  output logic                       done,
  output logic                       fail,
`ifdef BIST_CHECKER_ERR_COUNT_EN
  output logic [ERR_COUNT_WIDTH-1:0] err_count,
`endif
  output logic [ADDR_WIDTH-1:0]      fail_addr,
  output logic [DATA_WIDTH-1:0]      fail_expected,
  output logic [DATA_WIDTH-1:0]      fail_actual
);

  checker_state_t        state_q, state_d;
  logic                  accept_s;
  logic                  last_valid_s, any_valid_s;
  logic [ADDR_WIDTH-1:0] last_addr_s;
  logic [DATA_WIDTH-1:0] last_expected_s;
  logic                  mismatch_s, capture_s;
  logic                  done_q, fail_q;
  logic [ADDR_WIDTH-1:0] fail_addr_q;
  logic [DATA_WIDTH-1:0] fail_expected_q, fail_actual_q;

  assign accept_s = en & pg_re & accepts_reads(state_q);

  bist_read_pipe #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (READ_LATENCY)
  ) u_pipe (
    .clk_i       (clk),
    .rst_i       (rst),
    .valid_i     (accept_s),
    .addr_i      (pg_addr),
    .expected_i  (pg_expected),
    .valid_o     (last_valid_s),
    .addr_o      (last_addr_s),
    .expected_o  (last_expected_s),
    .any_valid_o (any_valid_s)
  );

  assign mismatch_s = last_valid_s & (last_expected_s != dout);
  assign capture_s  = mismatch_s & ~fail_q;

  // Next-state logic; the drain exit also folds in a same-cycle mismatch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = RUN; else state_d = IDLE;
      RUN:     if (en && pg_done) state_d = DRAIN; else state_d = RUN;
      DRAIN: begin
        if (!any_valid_s) state_d = (fail_q || mismatch_s) ? FAIL : PASS;
        else              state_d = DRAIN;
      end
      PASS:    state_d = PASS;
      FAIL:    state_d = FAIL;
      default: state_d = IDLE;
    endcase
  end

  // State, status and first-fail capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      done_q          <= 1'b0;
      fail_q          <= 1'b0;
      fail_addr_q     <= '0;
      fail_expected_q <= '0;
      fail_actual_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= is_terminal(state_d);
      if (capture_s) begin
        fail_q          <= 1'b1;
        fail_addr_q     <= last_addr_s;
        fail_expected_q <= last_expected_s;
        fail_actual_q   <= dout;
      end
    end
  end

  assign done          = done_q;
  assign fail          = fail_q;
  assign fail_addr     = fail_addr_q;
  assign fail_expected = fail_expected_q;
  assign fail_actual   = fail_actual_q;

`ifdef BIST_CHECKER_ERR_COUNT_EN
  logic [ERR_COUNT_WIDTH-1:0] err_q, err_d;

  // Saturating increment: holds at all-ones instead of wrapping.
  always_comb begin
    err_d = err_q;
    if (mismatch_s && (err_q != {ERR_COUNT_WIDTH{1'b1}})) begin
      err_d = err_q + {{(ERR_COUNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= '0;
    else     err_q <= err_d;
  end

  assign err_count = err_q;
`endif

endmodule

// File: tb/tb_bist_checker.sv
// Directed bench for bist_checker: two instances (read latency 1 and 3) share
// one patgen stream, each fed by its own SRAM model with injectable faults.
module tb_bist_checker;
  import bist_checker_pkg::*;

  logic        clk = 1'b0;
  logic        rst, en, pg_re, pg_done;
  logic [4:0]  pg_addr;
  logic [31:0] pg_expected;
  logic [31:0] dout1, dout3;
  logic [31:0] rd3 [3];
  logic        done1, fail1, done3, fail3;
  logic [4:0]  fa1, fa3;
  logic [31:0] fe1, fe3, fx1, fx3;
`ifdef BIST_CHECKER_ERR_COUNT_EN
  logic [15:0] ec1;
  logic [1:0]  ec3;
`endif

  logic [31:0] base_r;
  logic [31:0] fault [32];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bist_checker #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .READ_LATENCY(1), .ERR_COUNT_WIDTH(16)) dut1 (
    .clk(clk), .rst(rst), .en(en), .pg_addr(pg_addr), .pg_re(pg_re),
    .pg_expected(pg_expected), .pg_done(pg_done), .dout(dout1),
    .done(done1), .fail(fail1),
`ifdef BIST_CHECKER_ERR_COUNT_EN
    .err_count(ec1),
`endif
    .fail_addr(fa1), .fail_expected(fe1), .fail_actual(fx1));

  bist_checker #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .READ_LATENCY(3), .ERR_COUNT_WIDTH(2)) dut3 (
    .clk(clk), .rst(rst), .en(en), .pg_addr(pg_addr), .pg_re(pg_re),
    .pg_expected(pg_expected), .pg_done(pg_done), .dout(dout3),
    .done(done3), .fail(fail3),
`ifdef BIST_CHECKER_ERR_COUNT_EN
    .err_count(ec3),
`endif
    .fail_addr(fa3), .fail_expected(fe3), .fail_actual(fx3));

  function automatic logic [31:0] exp_word(input logic [4:0] a);
    return base_r ^ {32{a[0]}};
  endfunction

  function automatic logic [31:0] sram_word(input logic [4:0] a);
    return exp_word(a) ^ fault[a];
  endfunction

  // SRAM models with read latency 1 and 3.
  always @(posedge clk) begin
    dout1  <= sram_word(pg_addr);
    rd3[0] <= sram_word(pg_addr);
    rd3[1] <= rd3[0];
    rd3[2] <= rd3[1];
  end
  assign dout3 = rd3[2];

  task automatic idle_inputs();
    en = 1'b0; pg_re = 1'b0; pg_done = 1'b0; pg_addr = 5'd0; pg_expected = 32'd0;
  endtask

  task automatic clear_faults();
    for (int i = 0; i < 32; i++) fault[i] = 32'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Full sweep of addresses 0..31; optional en=0 bubbles; returns drain latency.
  task automatic sweep(input bit toggle_en, input bit stop_in_drain,
                       output int lat1, output int lat3);
    lat1 = 0; lat3 = 0;
    for (int a = 0; a < 32; a++) begin
      if (toggle_en && a >= 8 && a < 16) begin
        en = 1'b0; pg_re = 1'b1; pg_done = 1'b0;
        pg_addr = 5'(a); pg_expected = ~exp_word(5'(a));
        @(negedge clk);
      end
      en = 1'b1; pg_re = 1'b1; pg_addr = 5'(a);
      pg_expected = exp_word(5'(a)); pg_done = (a == 31);
      @(negedge clk);
    end
    // Late reads after pg_done carry wrong data and must be ignored.
    en = 1'b1; pg_re = 1'b1; pg_done = 1'b1; pg_addr = 5'd4; pg_expected = 32'h1234_5678;
    if (stop_in_drain) return;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (done1 && lat1 == 0) lat1 = k;
      if (done3 && lat3 == 0) lat3 = k;
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (done1 !== 1'b0 || done3 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b/%b expected 0/0", done1, done3); end
    checks++; if (fail1 !== 1'b0 || fail3 !== 1'b0) begin errors++; $display("FAIL reset_fail: got %b/%b expected 0/0", fail1, fail3); end
    checks++; if (fa1 !== 5'd0 || fa3 !== 5'd0) begin errors++; $display("FAIL reset_fail_addr: got %h/%h expected 0", fa1, fa3); end
    checks++; if (fe1 !== 32'd0 || fx1 !== 32'd0 || fe3 !== 32'd0 || fx3 !== 32'd0) begin errors++; $display("FAIL reset_capture: got %h %h %h %h expected 0", fe1, fx1, fe3, fx3); end
    checks++; if (dut1.state_q !== IDLE || dut3.state_q !== IDLE) begin errors++; $display("FAIL reset_state: got %0d/%0d expected IDLE", dut1.state_q, dut3.state_q); end
`ifdef BIST_CHECKER_ERR_COUNT_EN
    checks++; if (ec1 !== 16'd0 || ec3 !== 2'd0) begin errors++; $display("FAIL reset_err_count: got %0d/%0d expected 0", ec1, ec3); end
`endif
  endtask

  task automatic check_clean(input string name, input int lat1, input int lat3);
    checks++; if (done1 !== 1'b1 || done3 !== 1'b1) begin errors++; $display("FAIL %s_done: got %b/%b expected 1/1", name, done1, done3); end
    checks++; if (fail1 !== 1'b0 || fail3 !== 1'b0) begin errors++; $display("FAIL %s_fail: got %b/%b expected 0/0", name, fail1, fail3); end
    checks++; if (lat1 !== 2) begin errors++; $display("FAIL %s_latency_rl1: got %0d expected 2", name, lat1); end
    checks++; if (lat3 !== 4) begin errors++; $display("FAIL %s_latency_rl3: got %0d expected 4", name, lat3); end
`ifdef BIST_CHECKER_ERR_COUNT_EN
    checks++; if (ec1 !== 16'd0 || ec3 !== 2'd0) begin errors++; $display("FAIL %s_err_count: got %0d/%0d expected 0", name, ec1, ec3); end
`endif
  endtask

  task automatic test_clean_run();
    int l1, l3;
    do_reset(); clear_faults(); base_r = 32'h0000_0000;
    sweep(1'b0, 1'b0, l1, l3);
    check_clean("clean", l1, l3);
  endtask

  task automatic test_stuck_bit();
    int l1, l3;
    do_reset(); clear_faults(); base_r = 32'hFFFF_FFFF;
    fault[10] = 32'h0000_0001;
    sweep(1'b0, 1'b0, l1, l3);
    checks++; if (fail1 !== 1'b1 || done1 !== 1'b1 || dut1.state_q !== FAIL) begin errors++; $display("FAIL stuck_status_rl1: got fail=%b done=%b state=%0d", fail1, done1, dut1.state_q); end
    checks++; if (fail3 !== 1'b1 || done3 !== 1'b1 || dut3.state_q !== FAIL) begin errors++; $display("FAIL stuck_status_rl3: got fail=%b done=%b state=%0d", fail3, done3, dut3.state_q); end
    checks++; if (fa1 !== 5'h0A || fe1 !== 32'hFFFF_FFFF || fx1 !== 32'hFFFF_FFFE) begin errors++; $display("FAIL stuck_capture_rl1: got %h %h %h expected 0a ffffffff fffffffe", fa1, fe1, fx1); end
    checks++; if (fa3 !== 5'h0A || fe3 !== 32'hFFFF_FFFF || fx3 !== 32'hFFFF_FFFE) begin errors++; $display("FAIL stuck_capture_rl3: got %h %h %h expected 0a ffffffff fffffffe", fa3, fe3, fx3); end
    checks++; if (l1 !== 2 || l3 !== 4) begin errors++; $display("FAIL stuck_latency: got %0d/%0d expected 2/4", l1, l3); end
`ifdef BIST_CHECKER_ERR_COUNT_EN
    checks++; if (ec1 !== 16'd1 || ec3 !== 2'd1) begin errors++; $display("FAIL stuck_err_count: got %0d/%0d expected 1/1", ec1, ec3); end
`endif
  endtask

  task automatic test_multi_fault();
    int l1, l3;
    do_reset(); clear_faults(); base_r = 32'h0000_0000;
    fault[3] = 32'h0000_0100; fault[17] = 32'h8000_0000;
    sweep(1'b0, 1'b0, l1, l3);
    checks++; if (fail1 !== 1'b1 || fail3 !== 1'b1 || done1 !== 1'b1 || done3 !== 1'b1) begin errors++; $display("FAIL multi_status: got fail %b/%b done %b/%b expected all 1", fail1, fail3, done1, done3); end
    checks++; if (fa1 !== 5'h03 || fe1 !== 32'hFFFF_FFFF || fx1 !== 32'hFFFF_FEFF) begin errors++; $display("FAIL multi_capture_rl1: got %h %h %h expected 03 ffffffff fffffeff", fa1, fe1, fx1); end
    checks++; if (fa3 !== 5'h03 || fe3 !== 32'hFFFF_FFFF || fx3 !== 32'hFFFF_FEFF) begin errors++; $display("FAIL multi_capture_rl3: got %h %h %h expected 03 ffffffff fffffeff", fa3, fe3, fx3); end
`ifdef BIST_CHECKER_ERR_COUNT_EN
    checks++; if (ec1 !== 16'd2 || ec3 !== 2'd2) begin errors++; $display("FAIL multi_err_count: got %0d/%0d expected 2/2", ec1, ec3); end
`endif
  endtask

  task automatic test_latency_alignment();
    int l1, l3;
    do_reset(); clear_faults(); base_r = 32'h5555_AAAA;
    sweep(1'b1, 1'b0, l1, l3);
    check_clean("en_toggle", l1, l3);
  endtask

  task automatic test_saturation();
    int l1, l3;
    do_reset(); clear_faults(); base_r = 32'h0000_0000;
    fault[1] = 32'h1; fault[5] = 32'h1; fault[9] = 32'h1; fault[20] = 32'h1; fault[31] = 32'h1;
    sweep(1'b0, 1'b0, l1, l3);
    checks++; if (fa1 !== 5'h01 || fe1 !== 32'hFFFF_FFFF || fx1 !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sat_capture: got %h %h %h expected 01 ffffffff fffffffe", fa1, fe1, fx1); end
    checks++; if (dut1.state_q !== FAIL || dut3.state_q !== FAIL) begin errors++; $display("FAIL sat_state: got %0d/%0d expected FAIL", dut1.state_q, dut3.state_q); end
`ifdef BIST_CHECKER_ERR_COUNT_EN
    checks++; if (ec1 !== 16'd5) begin errors++; $display("FAIL sat_err_count_w16: got %0d expected 5", ec1); end
    checks++; if (ec3 !== 2'd3) begin errors++; $display("FAIL sat_err_count_w2: got %0d expected 3", ec3); end
    repeat (4) @(negedge clk);
    checks++; if (ec3 !== 2'd3) begin errors++; $display("FAIL sat_err_count_hold: got %0d expected 3", ec3); end
`endif
  endtask

  task automatic test_reset_mid_run();
    int l1, l3;
    do_reset(); clear_faults(); base_r = 32'h0000_0000;
    fault[2] = 32'h0000_0010;
    sweep(1'b0, 1'b1, l1, l3);
    checks++; if (dut1.state_q !== DRAIN || fail1 !== 1'b1) begin errors++; $display("FAIL midrst_pre: got state=%0d fail=%b expected DRAIN/1", dut1.state_q, fail1); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (fail1 !== 1'b0 || fail3 !== 1'b0 || done1 !== 1'b0 || done3 !== 1'b0) begin errors++; $display("FAIL midrst_status: got fail %b/%b done %b/%b expected 0", fail1, fail3, done1, done3); end
    checks++; if (fa1 !== 5'd0 || fe1 !== 32'd0 || fx1 !== 32'd0) begin errors++; $display("FAIL midrst_capture: got %h %h %h expected 0", fa1, fe1, fx1); end
    checks++; if (dut1.state_q !== IDLE || dut3.state_q !== IDLE) begin errors++; $display("FAIL midrst_state: got %0d/%0d expected IDLE", dut1.state_q, dut3.state_q); end
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    clear_faults();
    @(negedge clk);
    sweep(1'b0, 1'b0, l1, l3);
    check_clean("rerun", l1, l3);
  endtask

  initial begin
    rst = 1'b1;
    base_r = 32'd0;
    clear_faults();
    idle_inputs();
    test_reset();
    test_clean_run();
    test_stuck_bit();
    test_multi_fault();
    test_latency_alignment();
    test_saturation();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
